// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data load-store) arbiter in front
// of a single word-wide memory with a one-cycle read latency.
//
// Every transaction walks IDLE -> ISSUE -> WAIT -> RESP, one state per cycle.
// The request is seen in IDLE at cycle N. The memory strobe is issued at N+1,
// read data is captured at the end of N+2, and the ack is raised at N+3.
// All outputs come straight from registers.
//
// Optional feature: define MEM_ARB_RR_EN to replace fixed data-port priority
// with round-robin between the two ports on simultaneous requests.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   i_req, i_addr                  instruction fetch request / byte address
//   i_rdata, i_ack                 fetched word, one-cycle completion pulse
//   d_req, d_we, d_addr            data request, 1 = store, byte address
//   d_wdata, d_wmask               store data and byte enables
//   d_rdata, d_ack                 loaded word, one-cycle completion pulse
//   mem_addr                       word-aligned memory address
//   mem_rstrb, mem_wdata, mem_wmask  memory read strobe, write data, write enables
//   mem_rdata                      memory read data, valid the cycle after mem_rstrb
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t              r_state;
  logic                r_sel_d;
  logic                r_we;
  logic [31:0]         r_i_rdata;
  logic                r_i_ack;
  logic [31:0]         r_d_rdata;
  logic                r_d_ack;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rstrb;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_mem_wmask;
`ifdef MEM_ARB_RR_EN
  logic                r_last_d;
`endif

  logic                w_grant_d;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;

  // Grant decision, only consumed in IDLE when at least one request is present.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On contention the port that did not win last time goes first.
    w_grant_d = d_req && (!i_req || !r_last_d);
`else
    w_grant_d = d_req;
`endif
    w_we   = w_grant_d && d_we;
    w_addr = w_grant_d ? d_addr : i_addr;
  end

  // The memory-side registers double as the transaction latch: address,
  // direction, data and mask are captured once in IDLE and never re-sampled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_sel_d     <= 1'b0;
      r_we        <= 1'b0;
      r_i_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_rdata   <= '0;
      r_d_ack     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rstrb <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_d    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req || d_req) begin
            r_sel_d    <= w_grant_d;
            r_we       <= w_we;
            r_mem_addr <= w_addr & WORD_MASK;
            if (w_we) begin
              r_mem_wdata <= d_wdata;
              r_mem_wmask <= d_wmask;
              r_mem_rstrb <= 1'b0;
            end else begin
              r_mem_wmask <= '0;
              r_mem_rstrb <= 1'b1;
            end
`ifdef MEM_ARB_RR_EN
            r_last_d   <= w_grant_d;
`endif
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_rstrb <= 1'b0;
          r_mem_wmask <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (!r_we) begin
            if (r_sel_d) r_d_rdata <= mem_rdata;
            else         r_i_rdata <= mem_rdata;
          end
          if (r_sel_d) r_d_ack <= 1'b1;
          else         r_i_ack <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_ack     = r_i_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign mem_addr  = r_mem_addr;
  assign mem_rstrb = r_mem_rstrb;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (ADDR_W = 32).
// A transaction-level reference model predicts each cycle's outputs from
// the grant time of the current transaction. Directed scenarios run first,
// then a randomized phase with random requests, withdrawals, input
// scrambling after the latch, and occasional resets.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int c     = 0;

  // Reference model: one transaction in flight, described by its grant cycle.
  int          t_start = -100;
  bit          t_d;
  bit          t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_wmask;
  logic [31:0] t_rdata;
  logic [31:0] e_maddr  = '0;
  logic [31:0] e_irdata = '0;
  logic [31:0] e_drdata = '0;
  bit          last_d = 1'b0;
  bit          i_own = 1'b0;
  bit          d_own = 1'b0;
  bit          hold_both = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle and compare outputs with the model.
  task automatic tick();
    @(negedge clk);
    c++;
    if (c == t_start + 1) e_maddr = t_addr & 32'hFFFF_FFFC;
    if (c == t_start + 3 && !t_we) begin
      if (t_d) e_drdata = t_rdata;
      else     e_irdata = t_rdata;
    end
    chk("i_ack",     i_ack,     (c == t_start + 3) && !t_d);
    chk("d_ack",     d_ack,     (c == t_start + 3) && t_d);
    chk("mem_rstrb", mem_rstrb, (c == t_start + 1) && !t_we);
    chk("mem_wmask", mem_wmask, (c == t_start + 1 && t_we) ? t_wmask : 4'b0000);
    chk("mem_addr",  mem_addr,  e_maddr);
    chk("i_rdata",   i_rdata,   e_irdata);
    chk("d_rdata",   d_rdata,   e_drdata);
    if (c == t_start + 1 && t_we) chk("mem_wdata", mem_wdata, t_wdata);
    // Completion: requester drops its request unless it keeps re-requesting.
    if (c == t_start + 3) begin
      if (t_d) begin d_own = 1'b0; if (!hold_both) d_req = 1'b0; end
      else     begin i_own = 1'b0; if (!hold_both) i_req = 1'b0; end
    end
  endtask

  // Apply the model to the inputs driven for the current cycle.
  task automatic sample();
    bit g;
    if (c == t_start + 2) t_rdata = mem_rdata;
    if (!resetn) begin
      t_start  = -100;
      e_maddr  = '0;
      e_irdata = '0;
      e_drdata = '0;
      last_d   = 1'b0;
      i_own    = 1'b0;
      d_own    = 1'b0;
      i_req    = 1'b0;
      d_req    = 1'b0;
    end else if (c >= t_start + 4 && (i_req || d_req)) begin
      if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        g = !last_d;
`else
        g = 1'b1;
`endif
      end else begin
        g = d_req;
      end
      t_start = c;
      t_d     = g;
      t_we    = g ? d_we : 1'b0;
      t_addr  = g ? d_addr : i_addr;
      t_wdata = d_wdata;
      t_wmask = d_wmask;
      last_d  = g;
      if (g) d_own = 1'b1;
      else   i_own = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      sample();
    end
  endtask

  initial begin
    resetn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
    idle_cycles(3);

    // Single fetch, first request right after reset release.
    tick(); resetn = 1'b1; i_req = 1'b1; i_addr = 32'h6; mem_rdata = 32'h0000_0513; sample();
    idle_cycles(5);

    // Store: one-cycle write strobe, d_rdata untouched.
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    d_wmask = 4'b0011; sample();
    idle_cycles(5);

    // Withdrawal: i_req dropped during ISSUE, ack still arrives.
    tick(); i_req = 1'b1; i_addr = 32'h2468; mem_rdata = 32'hCAFE_0001; sample();
    tick(); i_req = 1'b0; i_addr = 32'hFFFF_FFFF; sample();
    idle_cycles(5);

    // Reset during WAIT of a load, then a fresh fetch.
    tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_rdata = 32'h1234_5678; sample();
    tick(); sample();
    tick(); resetn = 1'b0; sample();
    tick(); resetn = 1'b1; sample();
    tick(); i_req = 1'b1; i_addr = 32'h80; mem_rdata = 32'h0BAD_F00D; sample();
    idle_cycles(5);

    // Contention with both requests held continuously.
    hold_both = 1'b1;
    tick(); i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
    mem_rdata = 32'h5555_AAAA; sample();
    idle_cycles(16);
    hold_both = 1'b0;
    idle_cycles(10);

    // Randomized phase.
    for (int n = 0; n < 2000; n++) begin
      tick();
      resetn    = ($urandom_range(0, 199) != 0);
      mem_rdata = $urandom;
      if (i_own) begin
        if ($urandom_range(0, 3) == 0) i_req = 1'b0;
        i_addr = $urandom;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (d_own) begin
        if ($urandom_range(0, 3) == 0) d_req = 1'b0;
        d_addr = $urandom; d_we = $urandom_range(0, 1) != 0;
        d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_we = $urandom_range(0, 1) != 0;
        d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
      end
      sample();
    end

    tick(); resetn = 1'b1; sample();
    idle_cycles(12);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
